// File: rtl/ps2_cmd_sequencer_if.sv
// Handshake bundle between the bus register block, the PS/2 frame
// transmitter/receiver and the command sequencer.
interface ps2_cmd_sequencer_if;
    // Software command channel
    logic       cmd_valid;
    logic [7:0] cmd_data;
    logic       cmd_ready;
    // Frame transmitter
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       tx_done;
    // Frame receiver
    logic       rx_valid;
    logic [7:0] rx_data;
    // Scan-code path and command status
    logic       key_valid;
    logic [7:0] key_data;
    logic       cmd_ack;
    logic       cmd_err;
    logic       busy;

    // Sequencer side
    modport slave (
        input  cmd_valid, cmd_data, tx_busy, tx_done, rx_valid, rx_data,
        output cmd_ready, tx_start, tx_data, key_valid, key_data,
               cmd_ack, cmd_err, busy
    );

    // Environment side (register block, transmitter, receiver)
    modport master (
        output cmd_valid, cmd_data, tx_busy, tx_done, rx_valid, rx_data,
        input  cmd_ready, tx_start, tx_data, key_valid, key_data,
               cmd_ack, cmd_err, busy
    );
endinterface

// File: rtl/ps2_cmd_sequencer.sv
// PS/2 host command sequencer: sends one command byte, waits for the
// device acknowledge, resends on 0xFE, times out on silence, and forwards
// every receive byte it does not consume to the scan-code path.
module ps2_cmd_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 2000000,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic                 Bus2IP_Clk,
    input  logic                 Bus2IP_Resetn,
    ps2_cmd_sequencer_if.slave   bus
);
    // Guard the widths so degenerate parameter values still elaborate
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY);
    localparam logic [RW-1:0] RETRY_ONE  = RW'(1);
    localparam logic [7:0]    RX_ACK     = 8'hFA;
    localparam logic [7:0]    RX_RESEND  = 8'hFE;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_TX,
        ST_WAIT_ACK
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          cmd_ack_q, cmd_ack_d;
    logic          cmd_err_q, cmd_err_d;
    logic          key_valid_q, key_valid_d;
    logic [7:0]    key_data_q, key_data_d;
    logic          tx_start_c;
    logic          timeout_c;
    logic          rx_is_ack_c;
    logic          rx_is_resend_c;
    logic          rx_consumed_c;

    assign timeout_c      = (timer_q == TIMER_LAST);
    assign rx_is_ack_c    = bus.rx_valid && (bus.rx_data == RX_ACK);
    assign rx_is_resend_c = bus.rx_valid && (bus.rx_data == RX_RESEND);
    // Only acknowledge bytes that answer an outstanding command are swallowed
    assign rx_consumed_c  = (state_q == ST_WAIT_ACK) && (rx_is_ack_c || rx_is_resend_c);

    // State, counters, latched command and registered status outputs
    always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
        if (!Bus2IP_Resetn) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            retry_q     <= '0;
            tx_data_q   <= '0;
            cmd_ack_q   <= 1'b0;
            cmd_err_q   <= 1'b0;
            key_valid_q <= 1'b0;
            key_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            retry_q     <= retry_d;
            tx_data_q   <= tx_data_d;
            cmd_ack_q   <= cmd_ack_d;
            cmd_err_q   <= cmd_err_d;
            key_valid_q <= key_valid_d;
            key_data_q  <= key_data_d;
        end
    end

    // Next-state logic; rx acknowledge bytes and tx_done take priority over timeout
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        retry_d     = retry_q;
        tx_data_d   = tx_data_q;
        cmd_ack_d   = 1'b0;
        cmd_err_d   = 1'b0;
        tx_start_c  = 1'b0;
        key_valid_d = bus.rx_valid && !rx_consumed_c;
        key_data_d  = bus.rx_valid ? bus.rx_data : key_data_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    tx_data_d = bus.cmd_data;
                    retry_d   = '0;
                    state_d   = ST_SEND;
                end
            end
            ST_SEND: begin
                if (!bus.tx_busy) begin
                    tx_start_c = 1'b1;
                    timer_d    = '0;
                    state_d    = ST_WAIT_TX;
                end
            end
            ST_WAIT_TX: begin
                if (bus.tx_done) begin
                    timer_d = '0;
                    state_d = ST_WAIT_ACK;
                end else if (timeout_c) begin
                    cmd_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end
            ST_WAIT_ACK: begin
                if (rx_is_ack_c) begin
                    cmd_ack_d = 1'b1;
                    state_d   = ST_IDLE;
                end else if (rx_is_resend_c) begin
                    if (retry_q < RETRY_LAST) begin
                        retry_d = retry_q + RETRY_ONE;
                        state_d = ST_SEND;
                    end else begin
                        cmd_err_d = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end else if (timeout_c) begin
                    cmd_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.cmd_ready = (state_q == ST_IDLE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.tx_start  = tx_start_c;
    assign bus.tx_data   = tx_data_q;
    assign bus.cmd_ack   = cmd_ack_q;
    assign bus.cmd_err   = cmd_err_q;
    assign bus.key_valid = key_valid_q;
    assign bus.key_data  = key_data_q;
endmodule
